branch_predictor_ctrl: RTL

Controller that owns the fetch-stage branch target table (tag, target, 2-bit saturating counter per entry) and shares its single read/write port between two requesters. The two requesters are fetch-stage prediction lookups and execute-stage branch resolutions. Resolutions are buffered in a small FIFO and retired through a read-modify-write sequencer. An anti-starvation rule guarantees that updates complete even while fetch issues a lookup every cycle.

---
 rtl/branch_predictor_ctrl.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/branch_predictor_ctrl.sv
// Branch target table controller: arbitrates one table port between fetch lookups and queued resolution updates.
// Latency: prediction one cycle after grant; an update takes READ+WRITE (2 cycles), or 1 cycle for a discarded miss.
// Backpressure: resolve_ready drops when the resolution queue is full; lookups are refused while the sequencer owns the port.

// Generic FIFO used for the resolution queue. Pointers wrap modulo DEPTH.
// Latency: a pushed entry is visible at pop_dat the next cycle.
// Backpressure: the caller must not push when full or pop when empty.
module bpc_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves cnt unchanged.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module branch_predictor_ctrl #(
    parameter int ENTRIES    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE     = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        lookup_req,
    input  logic [31:0] lookup_pc,
    output logic        lookup_grant,
    output logic        pred_valid,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    output logic        resolve_ready,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    output logic        upd_busy
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;
    localparam int SW   = $clog2(STARVE + 1);

    typedef enum logic [1:0] {IDLE, UPD_READ, UPD_WRITE} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } res_t;

    // Branch target table
    logic            tbl_vld [ENTRIES];
    logic [TAGW-1:0] tbl_tag [ENTRIES];
    logic [31:0]     tbl_tgt [ENTRIES];
    logic [1:0]      tbl_cnt [ENTRIES];

    state_t          state;
    logic [SW-1:0]   starve_cnt;
    logic [IDX-1:0]  wr_idx;
    logic [TAGW-1:0] wr_tag;
    logic [31:0]     wr_tgt;
    logic [1:0]      wr_cnt;

    res_t            head;
    res_t            push_dat;
    logic            q_full;
    logic            q_empty;
    logic            q_push;
    logic            q_pop;
    logic            start_upd;

    logic [IDX-1:0]  lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDX-1:0]  hd_idx;
    logic [TAGW-1:0] hd_tag;
    logic            hd_hit;
    logic [1:0]      hd_cnt_nxt;
    logic            unused_pc_bits;

    assign push_dat = '{pc: resolve_pc, taken: resolve_taken, target: resolve_target};

    assign resolve_ready = !q_full;
    assign q_push        = resolve_valid && !q_full;

    bpc_fifo #(.W($bits(res_t)), .DEPTH(FIFO_DEPTH)) u_res_q (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (q_push),
        .push_dat (push_dat),
        .pop      (q_pop),
        .pop_dat  (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[31:IDX+2];
    assign lk_hit = tbl_vld[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

    assign hd_idx = head.pc[IDX+1:2];
    assign hd_tag = head.pc[31:IDX+2];
    assign hd_hit = tbl_vld[hd_idx] && (tbl_tag[hd_idx] == hd_tag);

    assign unused_pc_bits = ^{lookup_pc[1:0], head.pc[1:0]};

    // An update takes the port when the queue must drain, fetch is quiet, or fetch has starved it long enough.
    assign start_upd = (state == IDLE) && !q_empty &&
                       (q_full || !lookup_req || (starve_cnt == SW'(STARVE)));

    assign lookup_grant = lookup_req && (state == IDLE) && !start_upd;

    // Miss with not-taken outcome is dropped straight from READ; everything else pops after WRITE.
    assign q_pop = (state == UPD_WRITE) ||
                   ((state == UPD_READ) && !hd_hit && !head.taken);

    // Saturating 2-bit counter step for the head entry's outcome.
    always_comb begin
        hd_cnt_nxt = tbl_cnt[hd_idx];
        if (head.taken) begin
            if (tbl_cnt[hd_idx] != 2'b11) hd_cnt_nxt = tbl_cnt[hd_idx] + 2'b01;
        end else begin
            if (tbl_cnt[hd_idx] != 2'b00) hd_cnt_nxt = tbl_cnt[hd_idx] - 2'b01;
        end
    end

    // Update sequencer: READ computes the new entry, WRITE commits it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            upd_busy <= 1'b0;
            wr_idx   <= '0;
            wr_tag   <= '0;
            wr_tgt   <= '0;
            wr_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_upd) begin
                        state    <= UPD_READ;
                        upd_busy <= 1'b1;
                    end
                end
                UPD_READ: begin
                    wr_idx <= hd_idx;
                    wr_tag <= hd_tag;
                    if (hd_hit) begin
                        wr_cnt <= hd_cnt_nxt;
                        wr_tgt <= head.taken ? head.target : tbl_tgt[hd_idx];
                        state  <= UPD_WRITE;
                    end else if (head.taken) begin
                        wr_cnt <= 2'b10;
                        wr_tgt <= head.target;
                        state  <= UPD_WRITE;
                    end else begin
                        state    <= IDLE;
                        upd_busy <= 1'b0;
                    end
                end
                UPD_WRITE: begin
                    state    <= IDLE;
                    upd_busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    upd_busy <= 1'b0;
                end
            endcase
        end
    end

    // Table storage; written only in UPD_WRITE, so a reset mid-update never commits.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_vld[i] <= 1'b0;
                tbl_tag[i] <= '0;
                tbl_tgt[i] <= '0;
                tbl_cnt[i] <= 2'b00;
            end
        end else if (state == UPD_WRITE) begin
            tbl_vld[wr_idx] <= 1'b1;
            tbl_tag[wr_idx] <= wr_tag;
            tbl_tgt[wr_idx] <= wr_tgt;
            tbl_cnt[wr_idx] <= wr_cnt;
        end
    end

    // Count lookup grants that bypass a waiting update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (start_upd || q_empty) begin
            starve_cnt <= '0;
        end else if (lookup_grant) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Prediction registers: one-cycle pulse after a grant, zero otherwise.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_valid  <= lookup_grant;
            pred_hit    <= lookup_grant && lk_hit;
            pred_taken  <= lookup_grant && lk_hit && tbl_cnt[lk_idx][1];
            pred_target <= (lookup_grant && lk_hit) ? tbl_tgt[lk_idx] : 32'h0;
        end
    end
endmodule
